// File: rtl/mips_muldiv_unit_if.sv
// mips_muldiv_unit_if: request/result bundle between the EX stage and the mul/div unit
interface mips_muldiv_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, op, A, B, flush, input busy, done, div_by_zero, hi, lo);
    modport slave (input start, op, A, B, flush, output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: radix-2 multi-cycle multiply/divide with HI/LO registers
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic reset,
    mips_muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} stateType;
    stateType state, nextState;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] hiReg, loReg, hiAcc, loAcc, mReg;
    logic isDiv, negHi, negLo, divZero, accept, sgn;
    logic [WIDTH-1:0] aMag, bMag, nextHiAcc, nextLoAcc, resHi, resLo;
    logic [WIDTH:0] mulSum, shifted, diff;
    logic [2*WIDTH-1:0] product;
    // Acceptance and operand magnitudes; MTHI/MTLO share the path but ignore them
    always_comb begin
        sgn = ~bus.op[0];
        aMag = (sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
        bMag = (sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;
        accept = bus.start && !bus.flush && (state == IDLE || state == DONE) && (bus.op <= 3'd5);
    end
    // One iteration step and the final sign correction; a zero divisor leaves hiAcc = |A| so the sign fix restores A
    always_comb begin
        mulSum = {1'b0, hiAcc} + {1'b0, mReg & {WIDTH{loAcc[0]}}};
        shifted = {hiAcc, loAcc[WIDTH-1]};
        diff = shifted - {1'b0, mReg};
        nextHiAcc = isDiv ? (diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]) : mulSum[WIDTH:1];
        nextLoAcc = isDiv ? {loAcc[WIDTH-2:0], ~diff[WIDTH]} : {mulSum[0], loAcc[WIDTH-1:1]};
        product = negHi ? -{hiAcc, loAcc} : {hiAcc, loAcc};
        resHi = !isDiv ? product[2*WIDTH-1:WIDTH] : (negHi ? -hiAcc : hiAcc);
        resLo = !isDiv ? product[WIDTH-1:0] : (mReg == '0 ? '1 : (negLo ? -loAcc : loAcc));
    end
    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= nextState;
    end
    // Next-state logic; flush squashes RUN/FIX and blocks acceptance
    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE: nextState = accept ? (bus.op[2] ? DONE : RUN) : IDLE;
            RUN: nextState = bus.flush ? IDLE : (count == CNT_W'(1) ? FIX : RUN);
            FIX: nextState = bus.flush ? IDLE : DONE;
            default: nextState = IDLE;
        endcase
    end
    // Datapath: operand latch on accept, iterate in RUN, commit HI/LO in FIX
    always_ff @(posedge clk) begin
        if (reset) begin
            hiReg <= '0;
            loReg <= '0;
            hiAcc <= '0;
            loAcc <= '0;
            mReg <= '0;
            count <= '0;
            isDiv <= 1'b0;
            negHi <= 1'b0;
            negLo <= 1'b0;
            divZero <= 1'b0;
        end else if (accept) begin
            divZero <= 1'b0;
            if (bus.op == 3'd4) hiReg <= bus.A;
            if (bus.op == 3'd5) loReg <= bus.A;
            isDiv <= bus.op[1];
            negHi <= sgn && (bus.op[1] ? bus.A[WIDTH-1] : bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            negLo <= sgn && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            hiAcc <= '0;
            loAcc <= bus.op[1] ? aMag : bMag;
            mReg <= bus.op[1] ? bMag : aMag;
            count <= CNT_W'(WIDTH);
        end else if (state == RUN && !bus.flush) begin
            hiAcc <= nextHiAcc;
            loAcc <= nextLoAcc;
            count <= count - 1'b1;
        end else if (state == FIX && !bus.flush) begin
            hiReg <= resHi;
            loReg <= resLo;
            divZero <= isDiv && mReg == '0;
        end
    end
    assign bus.busy = (state == RUN) || (state == FIX);
    assign bus.done = (state == DONE);
    assign bus.div_by_zero = divZero;
    assign bus.hi = hiReg;
    assign bus.lo = loReg;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: directed vector table plus hand-written flush/reset/width-8 sequences
module tb_mips_muldiv_unit;
    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vecType;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    vecType vecs[14];
    mips_muldiv_unit_if #(.WIDTH(32)) bus();
    mips_muldiv_unit_if #(.WIDTH(8)) bus8();
    mips_muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    mips_muldiv_unit #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic ok);
        bus.op = op;
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy) lat++;
        end
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic ok);
        bus8.op = op;
        bus8.A = a;
        bus8.B = b;
        bus8.start = 1'b1;
        @(posedge clk);
        #1 bus8.start = 1'b0;
        lat = 0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus8.done) begin
                ok = 1'b1;
                break;
            end
            if (bus8.busy) lat++;
        end
    endtask

    initial begin
        int lat;
        logic ok;
        logic sawDone;
        vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
        vecs[2]  = '{3'd5, 32'h12345678, 32'h00000000, 32'hFFFFFFFE, 32'h12345678, 1'b0, 0};
        vecs[3]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[5]  = '{3'd2, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, 33};
        vecs[6]  = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 33};
        vecs[7]  = '{3'd0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 33};
        vecs[8]  = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33};
        vecs[9]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
        vecs[10] = '{3'd2, 32'hFFFFFFF6, 32'h00000000, 32'hFFFFFFF6, 32'hFFFFFFFF, 1'b1, 33};
        vecs[11] = '{3'd4, 32'h11111111, 32'h00000000, 32'h11111111, 32'hFFFFFFFF, 1'b0, 0};
        vecs[12] = '{3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, 33};
        vecs[13] = '{3'd3, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1, 33};
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op = 3'd0;
        bus.A = '0;
        bus.B = '0;
        bus8.start = 1'b0;
        bus8.flush = 1'b0;
        bus8.op = 3'd0;
        bus8.A = '0;
        bus8.B = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_done", {31'b0, bus.done}, 32'h0);
        check("rst_dbz", {31'b0, bus.div_by_zero}, 32'h0);
        check("rst8_hi", {24'b0, bus8.hi}, 32'h0);
        check("rst8_lo", {24'b0, bus8.lo}, 32'h0);
        check("rst8_busy", {31'b0, bus8.busy}, 32'h0);

        for (int i = 0; i < 14; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, lat, ok);
            check($sformatf("v%0d_done", i), {31'b0, ok}, 32'h1);
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_hi", i), bus.hi, vecs[i].hi);
            check($sformatf("v%0d_lo", i), bus.lo, vecs[i].lo);
            check($sformatf("v%0d_dbz", i), {31'b0, bus.div_by_zero}, {31'b0, vecs[i].dbz});
            check($sformatf("v%0d_busy", i), {31'b0, bus.busy}, 32'h0);
        end

        @(negedge clk);
        check("done_pulse", {31'b0, bus.done}, 32'h0);
        repeat (3) @(negedge clk);
        check("dbz_hold", {31'b0, bus.div_by_zero}, 32'h1);
        runOp(3'd5, 32'h0, 32'h0, lat, ok);
        check("dbz_clear", {31'b0, bus.div_by_zero}, 32'h0);
        check("dbz_clear_lo", bus.lo, 32'h0);

        bus.op = 3'd6;
        bus.A = 32'hDEADBEEF;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("rsv_busy", {31'b0, bus.busy}, 32'h0);
        check("rsv_done", {31'b0, bus.done}, 32'h0);
        check("rsv_hi", bus.hi, 32'h7);

        bus.op = 3'd4;
        bus.A = 32'h5;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
        @(negedge clk);
        check("idle_flush_done", {31'b0, bus.done}, 32'h0);
        check("idle_flush_hi", bus.hi, 32'h7);

        runOp(3'd4, 32'hAAAAAAAA, 32'h0, lat, ok);
        runOp(3'd5, 32'hAAAAAAAA, 32'h0, lat, ok);
        bus.op = 3'd0;
        bus.A = 32'h2;
        bus.B = 32'h3;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.op = 3'd5;
        bus.A = 32'h0;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("fl_busy_before", {31'b0, bus.busy}, 32'h1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("fl_busy", {31'b0, bus.busy}, 32'h0);
        check("fl_done", {31'b0, bus.done}, 32'h0);
        check("fl_hi", bus.hi, 32'hAAAAAAAA);
        check("fl_lo", bus.lo, 32'hAAAAAAAA);
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) sawDone = 1'b1;
        end
        check("fl_no_done", {31'b0, sawDone}, 32'h0);
        check("fl_lo_after", bus.lo, 32'hAAAAAAAA);

        bus.op = 3'd2;
        bus.A = 32'h64;
        bus.B = 32'h7;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("rs_busy_before", {31'b0, bus.busy}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rs_hi", bus.hi, 32'h0);
        check("rs_lo", bus.lo, 32'h0);
        check("rs_busy", {31'b0, bus.busy}, 32'h0);
        check("rs_done", {31'b0, bus.done}, 32'h0);
        check("rs_dbz", {31'b0, bus.div_by_zero}, 32'h0);
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) sawDone = 1'b1;
        end
        check("rs_no_done", {31'b0, sawDone}, 32'h0);

        run8(3'd0, 8'h7F, 8'h7F, lat, ok);
        check("w8_mul_done", {31'b0, ok}, 32'h1);
        check("w8_mul_lat", lat, 9);
        check("w8_mul_hi", {24'b0, bus8.hi}, 32'h3F);
        check("w8_mul_lo", {24'b0, bus8.lo}, 32'h01);
        run8(3'd2, 8'h80, 8'hFF, lat, ok);
        check("w8_div_done", {31'b0, ok}, 32'h1);
        check("w8_div_hi", {24'b0, bus8.hi}, 32'h00);
        check("w8_div_lo", {24'b0, bus8.lo}, 32'h80);
        check("w8_div_dbz", {31'b0, bus8.div_by_zero}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
